// File: rtl/envelope_gate.sv
// Noise gate: hysteretic envelope compare driving an attack/open/hold/release gain ramp.
// Optional macro ENVELOPE_GATE_FLOOR_EN adds a floor_gain input that sets the minimum closed gain.
module envelope_gate #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 8,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 16,
    parameter int HOLD_SAMPLES = 4
) (
    input  logic                    sample_clock,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] envelope_in,
    input  logic [SAMPLE_WIDTH-1:0] audio_in,
    input  logic [SAMPLE_WIDTH-1:0] open_thresh,
    input  logic [SAMPLE_WIDTH-1:0] close_thresh,
`ifdef ENVELOPE_GATE_FLOOR_EN
    input  logic [GAIN_WIDTH:0]     floor_gain,
`endif
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic [GAIN_WIDTH:0]     gain_out,
    output logic                    gate_open
);

    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 2;
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 2);
    localparam logic [GAIN_WIDTH:0]          UNITY_G     = (GAIN_WIDTH+1)'(1 << GAIN_WIDTH);
    localparam logic [GAIN_WIDTH+1:0]        ATTACK_INC  = (GAIN_WIDTH+2)'(ATTACK_STEP);
    localparam logic signed [GAIN_WIDTH+2:0] RELEASE_DEC = (GAIN_WIDTH+3)'(RELEASE_STEP);
    localparam logic [HOLD_W-1:0]            HOLD_LOAD   = HOLD_W'(HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0]            HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    gate_state_t                  state_r;
    logic [GAIN_WIDTH:0]          gain_r;
    logic [HOLD_W-1:0]            hold_cnt_r;
    logic [SAMPLE_WIDTH-1:0]      out_sample_r;
    logic                         gate_open_r;

    logic                         hi_s;
    logic                         lo_s;
    logic [GAIN_WIDTH:0]          floor_s;
    logic [GAIN_WIDTH+1:0]        attack_sum_s;
    logic signed [GAIN_WIDTH+2:0] release_diff_s;
    logic signed [PROD_W-1:0]     audio_ext_s;
    logic signed [PROD_W-1:0]     gain_ext_s;
    logic signed [PROD_W-1:0]     prod_s;

    // Threshold compares, ramp arithmetic and the gain multiply
    always_comb begin
        hi_s = (envelope_in >= open_thresh);
        lo_s = (envelope_in < close_thresh);
`ifdef ENVELOPE_GATE_FLOOR_EN
        if (floor_gain > UNITY_G) begin
            floor_s = UNITY_G;
        end else begin
            floor_s = floor_gain;
        end
`else
        floor_s = {(GAIN_WIDTH+1){1'b0}};
`endif
        attack_sum_s   = {1'b0, gain_r} + ATTACK_INC;
        release_diff_s = $signed({2'b00, gain_r}) - RELEASE_DEC;
        audio_ext_s    = $signed({{(GAIN_WIDTH+2){audio_in[SAMPLE_WIDTH-1]}}, audio_in});
        gain_ext_s     = $signed({{(SAMPLE_WIDTH+1){1'b0}}, gain_r});
        prod_s         = audio_ext_s * gain_ext_s;
    end

    // Gate state machine, gain ramp and registered outputs
    always_ff @(posedge sample_clock) begin
        if (rst) begin
            state_r      <= CLOSED;
            gain_r       <= {(GAIN_WIDTH+1){1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
            out_sample_r <= {SAMPLE_WIDTH{1'b0}};
            gate_open_r  <= 1'b0;
        end else begin
            // Slice equals (prod >>> GAIN_WIDTH) truncated; uses gain before this update
            out_sample_r <= prod_s[SAMPLE_WIDTH+GAIN_WIDTH-1:GAIN_WIDTH];
            case (state_r)
                CLOSED: begin
                    gain_r <= floor_s;
                    if (hi_s) begin
                        state_r     <= ATTACK;
                        gate_open_r <= 1'b1;
                    end else begin
                        gate_open_r <= 1'b0;
                    end
                end
                ATTACK: begin
                    if (lo_s) begin
                        state_r     <= RELEASE;
                        gate_open_r <= 1'b0;
                    end else if (attack_sum_s >= {1'b0, UNITY_G}) begin
                        gain_r      <= UNITY_G;
                        state_r     <= OPEN;
                        gate_open_r <= 1'b1;
                    end else begin
                        gain_r      <= attack_sum_s[GAIN_WIDTH:0];
                        gate_open_r <= 1'b1;
                    end
                end
                OPEN: begin
                    gain_r <= UNITY_G;
                    if (lo_s && (HOLD_SAMPLES > 0)) begin
                        hold_cnt_r  <= HOLD_LOAD;
                        state_r     <= HOLD;
                        gate_open_r <= 1'b1;
                    end else if (lo_s) begin
                        state_r     <= RELEASE;
                        gate_open_r <= 1'b0;
                    end else begin
                        gate_open_r <= 1'b1;
                    end
                end
                HOLD: begin
                    gain_r <= UNITY_G;
                    if (hi_s) begin
                        state_r     <= OPEN;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        gate_open_r <= 1'b1;
                    end else if (hold_cnt_r == HOLD_ONE) begin
                        state_r     <= RELEASE;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        gate_open_r <= 1'b0;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r - HOLD_ONE;
                        gate_open_r <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (hi_s) begin
                        state_r     <= ATTACK;
                        gate_open_r <= 1'b1;
                    end else if (release_diff_s <= $signed({2'b00, floor_s})) begin
                        gain_r      <= floor_s;
                        state_r     <= CLOSED;
                        gate_open_r <= 1'b0;
                    end else begin
                        gain_r      <= release_diff_s[GAIN_WIDTH:0];
                        gate_open_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= CLOSED;
                    gain_r      <= {(GAIN_WIDTH+1){1'b0}};
                    hold_cnt_r  <= {HOLD_W{1'b0}};
                    gate_open_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_sample = out_sample_r;
    assign gain_out   = gain_r;
    assign gate_open  = gate_open_r;

endmodule

// File: tb/tb_envelope_gate.sv
// Directed self-checking bench for envelope_gate with hand-computed gain/output sequences.
module tb_envelope_gate;

    logic        sample_clock = 1'b0;
    logic        rst;
    logic [23:0] envelope_in;
    logic [23:0] audio_in;
    logic [23:0] open_thresh;
    logic [23:0] close_thresh;
    logic [23:0] out_sample;
    logic [8:0]  gain_out;
    logic        gate_open;
`ifdef ENVELOPE_GATE_FLOOR_EN
    logic [8:0]  floor_gain = 9'd0;
`endif

    int tests  = 0;
    int errors = 0;

    envelope_gate dut (
        .sample_clock (sample_clock),
        .rst          (rst),
        .envelope_in  (envelope_in),
        .audio_in     (audio_in),
        .open_thresh  (open_thresh),
        .close_thresh (close_thresh),
`ifdef ENVELOPE_GATE_FLOOR_EN
        .floor_gain   (floor_gain),
`endif
        .out_sample   (out_sample),
        .gain_out     (gain_out),
        .gate_open    (gate_open)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic tick;
        @(posedge sample_clock);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; envelope_in = 24'hFFFFFF; audio_in = 24'd1000;
        open_thresh = 24'd1000; close_thresh = 24'd500;
        tick(); tick();
        tests++; if (out_sample !== 24'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out_sample); end
        tests++; if (gain_out !== 9'd0) begin errors++; $display("FAIL reset_gain: got %0d expected 0", gain_out); end
        tests++; if (gate_open !== 1'b0) begin errors++; $display("FAIL reset_gate: got %0b expected 0", gate_open); end
    endtask

    task automatic test_open_ramp;
        int exp_gain [6] = '{0, 64, 128, 192, 256, 256};
        int exp_out  [6] = '{0, 0, 1024, 2048, 3072, 4096};
        rst = 1'b0; envelope_in = 24'd1200; audio_in = 24'd4096;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++; if (gain_out !== 9'(exp_gain[k])) begin errors++; $display("FAIL ramp_gain[%0d]: got %0d expected %0d", k, gain_out, exp_gain[k]); end
            tests++; if ($signed(out_sample) !== exp_out[k]) begin errors++; $display("FAIL ramp_out[%0d]: got %0d expected %0d", k, $signed(out_sample), exp_out[k]); end
            tests++; if (gate_open !== 1'b1) begin errors++; $display("FAIL ramp_gate[%0d]: got %0b expected 1", k, gate_open); end
        end
    endtask

    task automatic test_hold_retrigger;
        envelope_in = 24'd400;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) envelope_in = 24'd1200;
            tick();
            tests++; if (gain_out !== 9'd256) begin errors++; $display("FAIL retrig_gain[%0d]: got %0d expected 256", k, gain_out); end
            tests++; if (gate_open !== 1'b1) begin errors++; $display("FAIL retrig_gate[%0d]: got %0b expected 1", k, gate_open); end
        end
    endtask

    task automatic test_release;
        int prev_gain = 256;
        int exp_gain;
        envelope_in = 24'd400; audio_in = 24'd4096;
        for (int k = 1; k <= 22; k++) begin
            exp_gain = (k <= 5) ? 256 : ((k >= 21) ? 0 : 256 - 16 * (k - 5));
            tick();
            tests++; if (gain_out !== 9'(exp_gain)) begin errors++; $display("FAIL rel_gain[%0d]: got %0d expected %0d", k, gain_out, exp_gain); end
            tests++; if (gate_open !== (k <= 4)) begin errors++; $display("FAIL rel_gate[%0d]: got %0b expected %0b", k, gate_open, (k <= 4)); end
            tests++; if ($signed(out_sample) !== prev_gain * 16) begin errors++; $display("FAIL rel_out[%0d]: got %0d expected %0d", k, $signed(out_sample), prev_gain * 16); end
            prev_gain = exp_gain;
        end
    endtask

    task automatic test_attack_abort;
        envelope_in = 24'd1200;
        tick(); tick(); tick();
        tests++; if (gain_out !== 9'd128) begin errors++; $display("FAIL abort_pre_gain: got %0d expected 128", gain_out); end
        envelope_in = 24'd400; audio_in = 24'hFFFFFD;
        tick();
        tests++; if (gain_out !== 9'd128) begin errors++; $display("FAIL abort_gain: got %0d expected 128", gain_out); end
        tests++; if (gate_open !== 1'b0) begin errors++; $display("FAIL abort_gate: got %0b expected 0", gate_open); end
        tests++; if ($signed(out_sample) !== -2) begin errors++; $display("FAIL abort_neg_out: got %0d expected -2", $signed(out_sample)); end
        tick();
        tests++; if (gain_out !== 9'd112) begin errors++; $display("FAIL abort_rel_gain: got %0d expected 112", gain_out); end
        tick();
        tests++; if ($signed(out_sample) !== -2) begin errors++; $display("FAIL abort_out112: got %0d expected -2", $signed(out_sample)); end
        tests++; if (gain_out !== 9'd96) begin errors++; $display("FAIL abort_gain96: got %0d expected 96", gain_out); end
        rst = 1'b1;
        tick();
        tests++; if (gain_out !== 9'd0) begin errors++; $display("FAIL midrel_rst_gain: got %0d expected 0", gain_out); end
        tests++; if (out_sample !== 24'd0) begin errors++; $display("FAIL midrel_rst_out: got %0d expected 0", out_sample); end
        tests++; if (gate_open !== 1'b0) begin errors++; $display("FAIL midrel_rst_gate: got %0b expected 0", gate_open); end
        rst = 1'b0; audio_in = 24'd4096;
        tick();
        tests++; if (gate_open !== 1'b0) begin errors++; $display("FAIL closed_gate: got %0b expected 0", gate_open); end
        envelope_in = 24'd1200;
        tick(); tick();
        tests++; if (gain_out !== 9'd64) begin errors++; $display("FAIL closed_reattack: got %0d expected 64", gain_out); end
    endtask

    task automatic test_threshold_edge;
        rst = 1'b1; tick();
        rst = 1'b0; envelope_in = 24'd1000;
        tick();
        tests++; if (gate_open !== 1'b1) begin errors++; $display("FAIL edge_open_eq: got %0b expected 1", gate_open); end
        envelope_in = 24'd500;
        tick();
        tests++; if (gain_out !== 9'd64) begin errors++; $display("FAIL edge_close_eq: got %0d expected 64", gain_out); end
    endtask

    task automatic test_misconfig;
        rst = 1'b1; tick();
        rst = 1'b0; open_thresh = 24'd500; close_thresh = 24'd1000; envelope_in = 24'd700;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (gate_open !== ((k % 2) == 0)) begin errors++; $display("FAIL mis_gate[%0d]: got %0b expected %0b", k, gate_open, ((k % 2) == 0)); end
            tests++; if (gain_out !== 9'd0) begin errors++; $display("FAIL mis_gain[%0d]: got %0d expected 0", k, gain_out); end
        end
    endtask

    initial begin
        test_reset();
        test_open_ramp();
        test_hold_retrigger();
        test_release();
        test_attack_abort();
        test_threshold_edge();
        test_misconfig();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
